// File: rtl/vmem_arbiter_if.sv
// Video-memory arbiter bus: display read port, two pixel writers, clear engine control, memory port.
interface vmem_arbiter_if #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 9,
  parameter int unsigned DW = 24
);
  localparam int unsigned AW = HW + VW;

  logic          disp_valid;
  logic [HW-1:0] disp_h;
  logic [VW-1:0] disp_v;
  logic [DW-1:0] disp_data;

  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  logic          clear_start;
  logic [DW-1:0] clear_color;
  logic          clear_busy;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  disp_valid, disp_h, disp_v,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_start, clear_color,
    input  mem_rdata,
    output disp_data, req0_ready, req1_ready, clear_busy,
    output mem_addr, mem_we, mem_wdata
  );

  // Environment side (display, requesters, memory)
  modport master (
    output disp_valid, disp_h, disp_v,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_start, clear_color,
    output mem_rdata,
    input  disp_data, req0_ready, req1_ready, clear_busy,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vmem_arbiter.sv
// Single-port frame-buffer arbiter: display reads own active video, writers and
// the clear-screen fill share the blanking slots.
module vmem_arbiter #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 9,
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  vmem_arbiter_if.slave bus
);
  localparam int unsigned AW = HW + VW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;  // 0: req0 won last, 1: req1 won last
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [DW-1:0] color_q, color_d;
  logic          disp_rd_q;

  logic          grant0_c, grant1_c;
  logic [AW-1:0] addr_c;
  logic          we_c;
  logic [DW-1:0] wdata_c;

  // State, fill counter, grant pointer and read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      clr_addr_q   <= '0;
      color_q      <= '0;
      disp_rd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_addr_q   <= clr_addr_d;
      color_q      <= color_d;
      disp_rd_q    <= bus.disp_valid;
    end
  end

  // Slot allocation, round-robin arbitration and fill sequencing
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_addr_d   = clr_addr_q;
    color_d      = color_q;
    grant0_c     = 1'b0;
    grant1_c     = 1'b0;
    addr_c       = '0;
    we_c         = 1'b0;
    wdata_c      = '0;

    if (bus.disp_valid) begin
      addr_c = {bus.disp_h, bus.disp_v};
    end else if (state_q == ST_CLEAR) begin
      we_c    = 1'b1;
      addr_c  = clr_addr_q;
      wdata_c = color_q;
      // Last address ends the fill; the counter holds rather than wrapping
      if (clr_addr_q == '1) begin
        state_d = ST_IDLE;
      end else begin
        clr_addr_d = clr_addr_q + AW'(1);
      end
    end else begin
      grant0_c = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1_c = bus.req1_valid && !grant0_c;
      if (grant0_c) begin
        we_c         = 1'b1;
        addr_c       = bus.req0_addr;
        wdata_c      = bus.req0_data;
        last_grant_d = 1'b0;
      end else if (grant1_c) begin
        we_c         = 1'b1;
        addr_c       = bus.req1_addr;
        wdata_c      = bus.req1_data;
        last_grant_d = 1'b1;
      end
    end

    // A clear request while already filling is dropped
    if ((state_q == ST_IDLE) && bus.clear_start) begin
      state_d    = ST_CLEAR;
      clr_addr_d = '0;
      color_d    = bus.clear_color;
    end
  end

  // Outputs are quiet while reset is held
  assign bus.mem_addr   = addr_c;
  assign bus.mem_wdata  = wdata_c;
  assign bus.mem_we     = we_c && !rst;
  assign bus.req0_ready = grant0_c && !rst;
  assign bus.req1_ready = grant1_c && !rst;
  assign bus.clear_busy = (state_q == ST_CLEAR);
  assign bus.disp_data  = (disp_rd_q && !rst) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Scoreboard bench for vmem_arbiter: a frame-buffer reference model predicts
// every cycle's handshake/status and every memory write; a monitor compares.
module tb_vmem_arbiter;
  localparam int unsigned TB_HW = 5;
  localparam int unsigned TB_VW = 4;
  localparam int unsigned AW    = TB_HW + TB_VW;
  localparam int          DEPTH = 1 << AW;

  typedef struct {
    logic          rst;
    logic          r0;
    logic          r1;
    logic          busy;
    logic          we;
    logic          chk_addr;
    logic [AW-1:0] addr;
    logic          chk_wdata;
    logic [23:0]   disp;
  } stat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vmem_arbiter_if #(.HW(TB_HW), .VW(TB_VW), .DW(24)) bus ();

  vmem_arbiter #(.HW(TB_HW), .VW(TB_VW), .DW(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Frame-buffer memory with 1-cycle synchronous read
  logic [23:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Reference model state
  logic [23:0] shadow [DEPTH];
  int          last;
  bit          fill_on;
  int          fill_next;
  logic [23:0] fill_col;
  bit          prev_read;
  logic [23:0] prev_val;

  // Requester stimulus state
  bit            p0, p1;
  logic [AW-1:0] a0, a1;
  logic [23:0]   d0, d1;

  stat_t stat_q[$];
  wr_t   wr_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic gen_reqs(input int pct0, input int pct1);
    if (!p0 && ($urandom_range(0, 99) < pct0)) begin
      p0 = 1'b1;
      a0 = AW'($urandom_range(0, DEPTH - 1));
      d0 = 24'($urandom);
    end
    if (!p1 && ($urandom_range(0, 99) < pct1)) begin
      p1 = 1'b1;
      a1 = AW'($urandom_range(0, DEPTH - 1));
      d1 = 24'($urandom);
    end
  endtask

  // One clock cycle: drive inputs, predict the outcome, queue expectations
  task automatic step(input logic r, input logic dv, input int h, input int v,
                      input logic cs, input logic [23:0] col);
    stat_t e;
    wr_t   w;
    int    addr;
    int    win;
    bit    busy0;
    @(posedge clk);
    #1;
    rst             = r;
    bus.disp_valid  = dv;
    bus.disp_h      = h[TB_HW-1:0];
    bus.disp_v      = v[TB_VW-1:0];
    bus.req0_valid  = p0;
    bus.req0_addr   = a0;
    bus.req0_data   = d0;
    bus.req1_valid  = p1;
    bus.req1_addr   = a1;
    bus.req1_data   = d1;
    bus.clear_start = cs;
    bus.clear_color = col;

    e = '{rst: r, r0: 1'b0, r1: 1'b0, busy: 1'b0, we: 1'b0, chk_addr: 1'b0,
          addr: '0, chk_wdata: 1'b0, disp: 24'h0};
    if (r) begin
      last      = 1;
      fill_on   = 1'b0;
      fill_next = 0;
      prev_read = 1'b0;
    end else begin
      busy0  = fill_on;
      e.busy = busy0;
      e.disp = prev_read ? prev_val : 24'h0;
      if (dv) begin
        addr       = h * (1 << TB_VW) + v;
        e.chk_addr = 1'b1;
        e.addr     = AW'(addr);
        prev_val   = shadow[addr];
      end else if (fill_on) begin
        e.we   = 1'b1;
        w.addr = AW'(fill_next);
        w.data = fill_col;
        wr_q.push_back(w);
        shadow[fill_next] = fill_col;
        fill_next++;
        if (fill_next == DEPTH) fill_on = 1'b0;
      end else begin
        if (p0 && p1) win = (last == 1) ? 0 : 1;
        else if (p0)  win = 0;
        else if (p1)  win = 1;
        else          win = -1;
        if (win < 0) begin
          e.chk_addr  = 1'b1;
          e.addr      = '0;
          e.chk_wdata = 1'b1;
        end else begin
          e.we   = 1'b1;
          e.r0   = (win == 0);
          e.r1   = (win == 1);
          w.addr = (win == 0) ? a0 : a1;
          w.data = (win == 0) ? d0 : d1;
          wr_q.push_back(w);
          shadow[int'(w.addr)] = w.data;
          last = win;
          if (win == 0) p0 = 1'b0;
          else          p1 = 1'b0;
        end
      end
      prev_read = dv;
      if (cs && !busy0) begin
        fill_on   = 1'b1;
        fill_next = 0;
        fill_col  = col;
      end
    end
    stat_q.push_back(e);
  endtask

  // Monitor: compare every cycle's outputs against the queued expectations
  initial begin
    stat_t e;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        e = stat_q.pop_front();
        check("req0_ready", 32'(bus.req0_ready), 32'(e.r0));
        check("req1_ready", 32'(bus.req1_ready), 32'(e.r1));
        check("mem_we", 32'(bus.mem_we), 32'(e.we));
        check("disp_data", 32'(bus.disp_data), 32'(e.disp));
        if (!e.rst) begin
          check("clear_busy", 32'(bus.clear_busy), 32'(e.busy));
          if (e.chk_addr)  check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
          if (e.chk_wdata) check("mem_wdata_idle", 32'(bus.mem_wdata), 32'h0);
          if (bus.mem_we === 1'b1) begin
            check("write_expected", 32'(wr_q.size() != 0), 32'h1);
            if (wr_q.size() != 0) begin
              w = wr_q.pop_front();
              check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
              check("wr_data", 32'(bus.mem_wdata), 32'(w.data));
            end
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = 24'(i * 32'h9E3779);
      shadow[i] = mem[i];
    end
    mem[5 * (1 << TB_VW) + 7]    = 24'h123456;
    shadow[5 * (1 << TB_VW) + 7] = 24'h123456;
    rst = 1'b1;
    bus.disp_valid = 1'b0; bus.disp_h = '0; bus.disp_v = '0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.clear_start = 1'b0; bus.clear_color = '0;
    p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    last = 1; fill_on = 1'b0; fill_next = 0; fill_col = '0;
    prev_read = 1'b0; prev_val = '0;

    repeat (3) step(1, 0, 0, 0, 0, 24'h0);

    // Display read, then a blank cycle
    step(0, 1, 5, 7, 0, 24'h0);
    step(0, 0, 0, 0, 0, 24'h0);
    step(0, 0, 0, 0, 0, 24'h0);

    // Write held off through active video
    p0 = 1'b1; a0 = AW'(1); d0 = 24'hFF0000;
    repeat (3) step(0, 1, 1, 2, 0, 24'h0);
    step(0, 0, 0, 0, 0, 24'h0);

    // Round-robin from reset, then req1 alone
    repeat (2) step(1, 0, 0, 0, 0, 24'h0);
    for (int i = 0; i < 4; i++) begin
      gen_reqs(100, 100);
      step(0, 0, 0, 0, 0, 24'h0);
    end
    for (int i = 0; i < 6; i++) begin
      gen_reqs(0, 100);
      step(0, i % 3 == 1, 3, 4, 0, 24'h0);
    end

    // Full clear with no display traffic; a request granted on the start cycle
    gen_reqs(100, 0);
    step(0, 0, 0, 0, 1, 24'h0000FF);
    for (int i = 0; i < DEPTH + 4; i++) begin
      gen_reqs(60, 60);
      step(0, 0, 0, 0, 0, 24'h0);
    end

    // Clear interleaved with display reads; a second start mid-fill is dropped
    step(0, 0, 0, 0, 1, 24'h00FF00);
    for (int i = 0; i < 2 * DEPTH + 6; i++) begin
      gen_reqs(30, 30);
      step(0, (i % 2) == 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
           i == 100, 24'hABCDEF);
    end

    // Reset mid-clear, then restart from address 0
    step(0, 0, 0, 0, 1, 24'h112233);
    for (int k = 0; k < 2000 && fill_next != 'h100; k++) step(0, 0, 0, 0, 0, 24'h0);
    step(1, 0, 0, 0, 0, 24'h0);
    step(0, 0, 0, 0, 0, 24'h0);
    step(0, 0, 0, 0, 1, 24'h445566);
    for (int i = 0; i < DEPTH + 40; i++) begin
      gen_reqs(50, 50);
      step(0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 31)),
           int'($urandom_range(0, 15)), 0, 24'h0);
    end

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      gen_reqs(40, 40);
      step($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
           $urandom_range(0, 399) == 0, 24'($urandom));
    end

    // Drain and compare final memory image
    step(1, 0, 0, 0, 0, 24'h0);
    @(posedge clk);
    #2;
    check("stat_q_drained", 32'(stat_q.size()), 32'h0);
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    for (int i = 0; i < DEPTH; i++) check("mem_image", 32'(mem[i]), 32'(shadow[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Arbitrates the single-port 24-bit video memory between the VGA scan-out read path and pixel writers: two write requesters (keyboard drawing engine, UART image loader) and a built-in clear-screen fill engine.
- Display reads own every active-video cycle. Writes are issued only in blanking slots.
- Sits between vga_ctrl (h_addr/v_addr/valid) and the frame-buffer memory, which is addressed by {h, v}.

Parameters:
HW, 10, horizontal address width
VW, 9, vertical address width
AW, HW+VW (19), memory address width
DW, 24, pixel width (RGB888)

Ports:
clk  in  1  system clock (pixel clock)
rst  in  1  synchronous, active-high reset
disp_valid  in  1  active-video flag from vga_ctrl (high = display needs a read this cycle)
disp_h  in  HW  display horizontal address
disp_v  in  VW  display vertical address
disp_data  out  DW  pixel to vga_ctrl
req0_valid  in  1  requester 0 write request
req0_addr  in  AW  requester 0 address {h, v}
req0_data  in  DW  requester 0 pixel
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid, req1_addr, req1_data, req1_ready  same as requester 0
clear_start  in  1  one-cycle pulse: fill the whole memory with clear_color
clear_color  in  DW  fill colour, sampled on the accepted clear_start
clear_busy  out  1  fill in progress
mem_addr  out  AW  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data (synchronous, 1-cycle latency)

Behaviour:
- Slot rule (combinational per cycle):
  - disp_valid=1: mem_addr={disp_h,disp_v}, mem_we=0, both ready=0.
  - disp_valid=0: the cycle is a free write slot.
- Display read path:
  - disp_rd_q <= disp_valid.
  - disp_data = disp_rd_q ? mem_rdata : 0, giving 1-cycle latency that matches vga_ctrl's registered pipeline.
- FSM states:
  - IDLE: free slots go to the requesters.
  - CLEAR: free slots go to the fill engine.
- IDLE arbitration:
  - Round-robin between valid requesters; last_grant pointer flips to the winner on each transfer.
  - A sole valid requester wins regardless of the pointer.
  - Granted requester: readyX=1, mem_addr=reqX_addr, mem_wdata=reqX_data, mem_we=1.
  - Transfer occurs when valid&&ready. Requesters hold valid/addr/data stable until ready. ready may depend combinationally on valid.
  - No free slot or no valid: mem_we=0, mem_addr=0, mem_wdata=0.
- IDLE -> CLEAR on clear_start:
  - Latch clear_color, set clr_addr=0.
  - clear_busy=1 from the next cycle.
  - A request granted in the same cycle as clear_start completes normally.
- CLEAR:
  - Both ready=0.
  - On each free slot: mem_we=1, mem_addr=clr_addr, mem_wdata=latched colour, clr_addr++.
  - Display cycles stall the fill; no address is skipped.
  - The write to address 2^AW-1 is the last one. The next cycle state=IDLE and clear_busy=0.
  - No wrap: the counter stops, no second pass.
  - clear_start while busy is ignored; the colour is not re-latched.
- Reset (synchronous): state=IDLE, last_grant=1 (req0 wins the first tie), clr_addr=0, disp_rd_q=0, clear_busy=0.
- While rst=1: mem_we=0, req0_ready=req1_ready=0, disp_data=0.
- Reset mid-clear aborts the fill. Memory is left partially filled; nothing is restored.
- Address width: AW bits, unsigned; no bounds check. Requester addresses with v>=480 or h>=640 are written as given.

Test Plan:
- Display read: disp_valid=1, h=5, v=7 -> mem_addr=0x00A07, mem_we=0. Memory returns 0x123456 -> disp_data=0x123456 one cycle later. With disp_valid=0 the following cycle -> disp_data=0 the cycle after.
- Blanking gating: req0_valid=1, addr=0x00001, data=0xFF0000, held through disp_valid=1 for 3 cycles -> req0_ready=0 for those 3 cycles. First disp_valid=0 cycle -> req0_ready=1, mem_we=1, mem_wdata=0xFF0000.
- Round-robin: both requesters valid over 4 consecutive blanking cycles after reset -> grants req0, req1, req0, req1. Only req1 valid -> req1 granted every free cycle.
- Clear: clear_start with clear_color=0x0000FF, disp_valid held 0 -> clear_busy high for exactly 2^19 cycles. Writes cover addresses 0..0x7FFFF in order with data 0x0000FF. Requester ready=0 throughout. IDLE restored afterwards.
- Clear with display interleave: disp_valid pattern 1,0,1,0 -> clear writes only on the 0 cycles, addresses consecutive, none skipped. A second clear_start mid-fill is ignored.
- Reset mid-clear: rst at clr_addr=0x00100 -> next cycle clear_busy=0, state IDLE. A new clear_start restarts the fill at address 0.
